// File: rtl/mem_pkg.sv
// Shared definitions for the main memory model: word geometry, FSM states
// and the power-up content function of the backing array.
package mem_pkg;

    localparam int unsigned ADDR_W = 10;  // {index[1:0], tag[7:0]}
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;   // holds LATENCY-1 for LATENCY up to 15
    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } mem_state_e;

    // Power-up content of word a is the low byte of its address.
    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] addr);
        return addr[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous write, registered read.
// Cells hold the difference from the power-up pattern, so an all-zero
// storage state reads back as mem[a] = a[7:0] with no init sequence and
// without any dependence on reset.
module mem_array
    import mem_pkg::*;
(
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] delta_q [Depth];
    logic [DATA_W-1:0] rdata_q;

    // One access per enabled edge: either commit a write or register a read.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                delta_q[addr_i] <= wdata_i ^ init_word(addr_i);
            end else begin
                rdata_q <= delta_q[addr_i] ^ init_word(addr_i);
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory.sv
// Fixed-latency main memory behind a cache: accepts one load or write-back
// in IDLE, waits LATENCY cycles in BUSY, then pulses a one-cycle response.
// Optional build macro: MAIN_MEMORY_STATS_EN enables the completed load /
// write-back counters; without it rd_count/wr_count read as zero.
module main_memory
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = 3  // legal range 1..15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_write,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count
);

    localparam logic [CNT_W-1:0] CntInit = CNT_W'(LATENCY - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // State and latched request; everything returns to IDLE on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    // Next-state logic; the array is touched only on the edge entering RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        mem_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    cnt_d   = CntInit;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    // A reset on this edge aborts the request, so no commit.
                    mem_en  = ~reset;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_we = mem_en & write_q;

    mem_array u_mem_array (
        .clk_i   (clock),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    // Response fields are forced to zero outside RESP so reset values hold
    // even though the array read register itself is not reset.
    assign ready      = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_write = (state_q == StResp) & write_q;
    assign resp_rdata = (state_q == StResp && !write_q) ? mem_rdata : '0;

`ifdef MAIN_MEMORY_STATS_EN
    logic [STAT_W-1:0] rd_count_q;
    logic [STAT_W-1:0] wr_count_q;

    // Count completed requests during their RESP cycle; wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (state_q == StResp) begin
            if (write_q) begin
                wr_count_q <= wr_count_q + 1'b1;
            end else begin
                rd_count_q <= rd_count_q + 1'b1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 Parameter: LATENCY, 3, number of BUSY cycles between request acceptance and response (legal range 1..15).
REQ-002 Parameter: ADDR_W, 10, word address width ({index[1:0], tag[7:0]}); DATA_W, 8, word width.
REQ-003 Port: clock  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  1  cache miss/write-back request present.
REQ-006 Port: req_write  input  1  1 = write-back, 0 = block load.
REQ-007 Port: req_addr  input  ADDR_W  word address.
REQ-008 Port: req_wdata  input  DATA_W  write-back data.
REQ-009 Port: ready  output  1  request may be accepted this cycle.
REQ-010 Port: resp_valid  output  1  one-cycle response pulse.
REQ-011 Port: resp_rdata  output  DATA_W  load data, valid only with resp_valid && !resp_write.
REQ-012 Port: resp_write  output  1  echoes req_write of the completed request.
REQ-013 Port: rd_count, wr_count  output  16 each  completed loads / write-backs.

Function
REQ-014 FSM states IDLE, BUSY, RESP; ready = 1 only in IDLE.
REQ-015 Accept at rising edge where req_valid && ready; latch addr, wdata, write flag; IDLE -> BUSY, counter loaded with LATENCY-1.
REQ-016 BUSY decrements counter each cycle; at counter 0 -> RESP on next edge.
REQ-017 Write commits to the array on the edge entering RESP; load data is read on the same edge (reads pre-write contents of other addresses only).
REQ-018 RESP lasts exactly one cycle with resp_valid = 1, then -> IDLE; no back-to-back acceptance in RESP.
REQ-019 Request accepted at edge N yields resp_valid high in the cycle following edge N+LATENCY.
REQ-020 No backpressure on response; the consumer must take it in the RESP cycle.
REQ-021 req_* inputs ignored outside IDLE; changing them during BUSY has no effect.
REQ-022 Array initial content: mem[a] = a[7:0] for all a; reset does not alter contents.
REQ-023 Load to an address written earlier returns the last committed write-back value.
REQ-024 Counters increment on the RESP cycle, wrap 0xFFFF -> 0x0000.

Reset
REQ-025 On reset: state IDLE, ready = 1, resp_valid = 0, resp_rdata = 0, resp_write = 0, counters = 0.
REQ-026 Reset during BUSY aborts the request; a pending write SHALL NOT commit.
REQ-027 Reset asserted in the RESP cycle: the write has already committed, resp_valid still drops on the next edge.

Configuration
REQ-028 Macro MAIN_MEMORY_STATS_EN: defined -> rd_count/wr_count implemented per REQ-024.
REQ-029 Undefined -> rd_count/wr_count tied to 0, no counter registers; ports remain present.

Structure
REQ-030 Shared package mem_pkg holds ADDR_W, DATA_W, and the FSM state enum (IDLE, BUSY, RESP).
REQ-031 One sub-module mem_array: single port, synchronous write, registered read, initial content per REQ-022; FSM and counters in main_memory.

Verification
REQ-032 Reset, then load addr 0x004 (LATENCY=3) -> ready low 4 cycles, resp_valid pulse 3 edges after accept, resp_rdata = 0x04, rd_count = 1.
REQ-033 Write-back addr 0x206 data 0x03, then load 0x206 -> second response resp_rdata = 0x03, wr_count = 1, rd_count = 1.
REQ-034 req_valid held high continuously -> exactly one acceptance per LATENCY+2 cycles, no response overlap.
REQ-035 Write-back 0x101 data 0xAA, reset pulsed during BUSY, then load 0x101 -> resp_rdata = 0x01 (write aborted).
REQ-036 Toggle req_addr/req_wdata during BUSY -> response reflects latched request only.
REQ-037 Build without MAIN_MEMORY_STATS_EN, run REQ-032 -> rd_count and wr_count remain 0.
